// File: rtl/decade_clock_scheduler.sv
// decade_clock_scheduler
// One 8-digit BCD prescaler chain on the 100 MHz board clock drives a
// registered square-wave enable (clk_out) at a runtime-selected decade rate,
// 10 MHz (code 0) down to 1 Hz (code 7). Rate requests use a valid/ready
// handshake and are committed only at a phase boundary shared by the old and
// new rates, so clk_out never glitches.
// Optional feature macro: TICKS_OUT_EN adds tick[7:0], per-rate one-cycle strobes.
module decade_clock_scheduler #(
    parameter logic [2:0] RESET_SEL = 3'd5
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [2:0] sel_req,
    input  logic       sel_valid,
    output logic       sel_ready,
    output logic [2:0] sel_cur,
    output logic       switch_done,
    output logic       clk_out
`ifdef TICKS_OUT_EN
    ,
    output logic [7:0] tick
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        DONE
    } state_t;

    logic [3:0] digit_q [8];
    logic [3:0] digit_d [8];
    logic [8:0] carry;          // carry[k]: digit k advances on this edge
    logic [7:0] wrap;           // wrap[k]: next d0..dk are all zero (rate-k boundary)
    logic [2:0] span;           // slower of current and pending rate

    state_t     state_q, state_d;
    logic [2:0] pend_q, pend_d;
    logic [2:0] sel_cur_q, sel_cur_d;
    logic       switch_done_q, switch_done_d;
    logic       clk_out_q, clk_out_d;

    // Next value of the BCD chain: ripple the carry through digits sitting at 9.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            digit_d[k]   = digit_q[k];
            carry[k + 1] = carry[k] && (digit_q[k] == 4'd9);
            if (carry[k]) begin
                digit_d[k] = (digit_q[k] == 4'd9) ? 4'd0 : digit_q[k] + 4'd1;
            end
        end
        wrap = carry[8:1];
    end

    // Handshake FSM and output phase: accept, wait for the shared boundary, commit.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so no
        // path leaves a variable unassigned, which would infer a latch.
        state_d       = state_q;
        pend_d        = pend_q;
        sel_cur_d     = sel_cur_q;
        switch_done_d = 1'b0;
        clk_out_d     = (digit_d[sel_cur_q] >= 4'd5);
        span          = (pend_q > sel_cur_q) ? pend_q : sel_cur_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    pend_d = sel_req;
                    if (sel_req == sel_cur_q) begin
                        state_d       = DONE;
                        switch_done_d = 1'b1;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                // Boundary of the slower rate is a low point for both rates.
                if (wrap[span]) begin
                    sel_cur_d     = pend_q;
                    clk_out_d     = 1'b0;
                    switch_done_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset also drops any pending request.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            // NOTE: the digit array is only eight 4-bit flops, not a RAM, so it
            // is reset like any other register to give a known phase.
            for (int k = 0; k < 8; k++) begin
                digit_q[k] <= 4'd0;
            end
            state_q       <= IDLE;
            pend_q        <= RESET_SEL;
            sel_cur_q     <= RESET_SEL;
            switch_done_q <= 1'b0;
            clk_out_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational blocks.
            for (int k = 0; k < 8; k++) begin
                digit_q[k] <= digit_d[k];
            end
            state_q       <= state_d;
            pend_q        <= pend_d;
            sel_cur_q     <= sel_cur_d;
            switch_done_q <= switch_done_d;
            clk_out_q     <= clk_out_d;
        end
    end

    assign sel_ready   = (state_q == IDLE);
    assign sel_cur     = sel_cur_q;
    assign switch_done = switch_done_q;
    assign clk_out     = clk_out_q;

`ifdef TICKS_OUT_EN
    logic [7:0] tick_q;

    // Per-rate strobes: tick[k] fires on the edge where d0..dk all roll to 0.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tick_q <= '0;
        end else begin
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_decade_clock_scheduler.sv
// Self-checking bench for decade_clock_scheduler (instance built with RESET_SEL = 0).
// The reference model works on the absolute edge count since reset release:
// a rate-c output is high when (n mod 10^(c+1)) >= 5*10^c, and a switch
// accepted at edge e commits at the next multiple of 10^(m+1) after e.
module tb_decade_clock_scheduler;

    localparam logic [2:0] RST_SEL = 3'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sel_req = 3'd0;
    logic       sel_valid = 1'b0;
    logic       sel_ready;
    logic [2:0] sel_cur;
    logic       switch_done;
    logic       clk_out;
`ifdef TICKS_OUT_EN
    logic [7:0] tick;
`endif

    int checks = 0;
    int errors = 0;

    decade_clock_scheduler #(.RESET_SEL(RST_SEL)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .sel_req    (sel_req),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_cur    (sel_cur),
        .switch_done(switch_done),
        .clk_out    (clk_out)
`ifdef TICKS_OUT_EN
        ,
        .tick       (tick)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model (edge-count arithmetic) ----------------
    int         mn;        // edges since reset release
    int         ready_at;  // sel_ready is high once mn >= ready_at
    int         done_at;   // edge after which switch_done is high
    int         cur_at;    // edge at which the pending rate takes over
    logic [2:0] m_cur;
    logic [2:0] m_new;

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h want %0h", name, mn, act, exp);
        end
    endtask

    task automatic model_reset();
        mn       = 0;
        ready_at = 0;
        done_at  = -1;
        cur_at   = -1;
        m_cur    = RST_SEL;
        m_new    = RST_SEL;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] r);
        int e;
        int p;
        int m;
        e = mn + 1;
        if (v && mn >= ready_at) begin
            if (r == m_cur) begin
                done_at  = e;
                ready_at = e + 1;
            end else begin
                m        = (int'(r) > int'(m_cur)) ? int'(r) : int'(m_cur);
                p        = p10(m + 1);
                cur_at   = (e / p + 1) * p;
                done_at  = cur_at;
                ready_at = cur_at;
                m_new    = r;
            end
        end
        mn = e;
        if (mn == cur_at) m_cur = m_new;
    endtask

    task automatic compare();
        int per;
        per = p10(int'(m_cur) + 1);
        check("sel_ready", sel_ready, mn >= ready_at);
        check("switch_done", switch_done, mn == done_at);
        check("sel_cur", sel_cur, m_cur);
        check("clk_out", clk_out, (mn % per) >= (per / 2));
`ifdef TICKS_OUT_EN
        for (int k = 0; k < 8; k++) begin
            check("tick", tick[k], (mn > 0) && ((mn % p10(k + 1)) == 0));
        end
`endif
    endtask

    // One active edge: model sees the inputs the DUT samples, compare on negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge(sel_valid, sel_req);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        sel_req   = 3'd0;
        model_reset();
        #1;
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_sel_ready", sel_ready, 1'b1);
        check("rst_sel_cur", sel_cur, RST_SEL);
        check("rst_switch_done", switch_done, 1'b0);
`ifdef TICKS_OUT_EN
        check("rst_tick", tick, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present a one-cycle request so that edge e samples it.
    task automatic request(input int e, input logic [2:0] r);
        while (mn < e - 1) cycle();
        // NOTE: inputs are driven with blocking assignments at the negedge,
        // well away from the edge where the DUT samples them.
        sel_valid = 1'b1;
        sel_req   = r;
        cycle();
        sel_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int edge_n);
        edge_n = -1;
        for (int i = 0; i < bound; i++) begin
            if (switch_done) begin
                edge_n = mn;
                break;
            end
            cycle();
        end
    endtask

    typedef struct {
        int         acc_edge;
        logic [2:0] req;
        int         exp_done_edge;
        logic [2:0] exp_cur;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int done_cnt;

        // Expected switch edges from a fresh reset at rate 0.
        vecs[0] = '{3,    3'd1, 100,  3'd1};  // slow-down
        vecs[1] = '{3,    3'd0, 3,    3'd0};  // same rate, low phase
        vecs[2] = '{7,    3'd0, 7,    3'd0};  // same rate, high phase
        vecs[3] = '{99,   3'd1, 100,  3'd1};  // one cycle before boundary
        vecs[4] = '{100,  3'd1, 200,  3'd1};  // accepted on a boundary edge
        vecs[5] = '{1,    3'd2, 1000, 3'd2};
        vecs[6] = '{57,   3'd2, 1000, 3'd2};
        vecs[7] = '{1000, 3'd2, 2000, 3'd2};  // accepted on a boundary edge

        // Reset phase: rate 0 high after edges 5-9, 15-19.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cycle();
            check("reset_phase_clk", clk_out, (i % 10) >= 5);
        end

        // Table-driven switch latencies.
        for (int i = 0; i < NV; i++) begin
            do_reset();
            request(vecs[i].acc_edge, vecs[i].req);
            wait_done(2500, got);
            check("vec_done_edge", got, vecs[i].exp_done_edge);
            check("vec_sel_cur", sel_cur, vecs[i].exp_cur);
        end

        // Slow-down detail: ready drop and new-rate phase.
        do_reset();
        request(3, 3'd1);
        check("slow_ready_low", sel_ready, 1'b0);
        while (mn < 149) cycle();
        check("slow_clk_149", clk_out, 1'b0);
        cycle();
        check("slow_clk_150", clk_out, 1'b1);
        while (mn < 199) cycle();
        check("slow_clk_199", clk_out, 1'b1);
        cycle();
        check("slow_clk_200", clk_out, 1'b0);

        // Speed-up: rate 2 -> 0 accepted at 1234 switches at 2000.
        do_reset();
        request(1, 3'd2);
        wait_done(1100, got);
        check("speed_first_switch", got, 1000);
        request(1234, 3'd0);
        wait_done(1000, got);
        check("speed_switch_edge", got, 2000);
        check("speed_sel_cur", sel_cur, 3'd0);
        while (mn < 2004) cycle();
        check("speed_clk_2004", clk_out, 1'b0);
        cycle();
        check("speed_clk_2005", clk_out, 1'b1);

        // Busy request while pending is ignored.
        do_reset();
        request(3, 3'd1);
        request(20, 3'd2);
        wait_done(200, got);
        check("busy_switch_edge", got, 100);
        check("busy_sel_cur", sel_cur, 3'd1);

        // Asynchronous reset while a switch is pending.
        do_reset();
        request(1, 3'd2);
        while (mn < 7) cycle();
        check("midpend_clk_before", clk_out, 1'b1);
        check("midpend_ready_before", sel_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midpend_clk_now", clk_out, 1'b0);
        check("midpend_ready_now", sel_ready, 1'b1);
        check("midpend_cur_now", sel_cur, RST_SEL);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            cycle();
            if (switch_done) done_cnt++;
        end
        check("midpend_no_done", done_cnt, 0);

        // Randomized requests against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel_valid = ($urandom_range(0, 7) == 0);
            sel_req   = 3'($urandom_range(0, 2));
            cycle();
        end
        sel_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
